// File: rtl/ram16k_pkg.sv
// Shared constants and state encoding for the RAM16K two-port arbiter.
package ram16k_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/ram16k_arbiter_rr_arb2.sv
// Two-way round-robin picker: purely combinational winner selection.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_idx,
  output logic       any
);
  import ram16k_pkg::*;

  // A lone requester wins outright; on contention the side holding priority wins.
  always_comb begin
    any     = |req;
    gnt_idx = PORT_A;
    case (req)
      2'b10:   gnt_idx = PORT_B;
      2'b11:   gnt_idx = prio;
      default: gnt_idx = PORT_A;
    endcase
  end

endmodule

// File: rtl/ram16k_arbiter.sv
// Two-requester round-robin sequencer in front of a single RAM16K.
// One command at a time: IDLE -> ACCESS -> [WAIT x (RD_LAT-1)] -> DONE -> IDLE for reads,
// IDLE -> ACCESS -> IDLE for writes.
module ram16k_arbiter #(
  parameter int ADDR_W = ram16k_pkg::ADDR_W,
  parameter int DATA_W = ram16k_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_e,
  output logic              ram_w,
  output logic              ram_r,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  import ram16k_pkg::*;

  // Counter only needs to hold RD_LAT-2 (the WAIT cycles remaining after the first).
  localparam int               CNT_W     = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam bit               HAS_WAIT  = (RD_LAT > 1);

  state_e              state_reg, state_next;
  logic                prio_reg;
  logic                owner_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                a_rvalid_reg, b_rvalid_reg;
  logic [DATA_W-1:0]   a_rdata_reg, b_rdata_reg;
  logic                win;
  logic                any_req;

  rr_arb2 u_arb (
    .req     ({b_req, a_req}),
    .prio    (prio_reg),
    .gnt_idx (win),
    .any     (any_req)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Latch the winning command and hand priority to the loser on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_reg  <= PORT_A;
      owner_reg <= PORT_A;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (state_reg == ST_IDLE && any_req) begin
      owner_reg <= win;
      prio_reg  <= ~win;
      we_reg    <= (win == PORT_B) ? b_we    : a_we;
      addr_reg  <= (win == PORT_B) ? b_addr  : a_addr;
      wdata_reg <= (win == PORT_B) ? b_wdata : a_wdata;
    end
  end

  // Read-latency counter: loaded on ACCESS, counts down through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt_reg <= '0;
    else if (state_reg == ST_ACCESS) cnt_reg <= WAIT_LOAD;
    else if (state_reg == ST_WAIT)   cnt_reg <= cnt_reg - 1'b1;
  end

  // Next-state and RAM strobe / grant decode.
  always_comb begin
    state_next = state_reg;
    ram_e      = 1'b0;
    ram_w      = 1'b0;
    ram_r      = 1'b0;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        ram_e = 1'b1;
        ram_w = we_reg;
        ram_r = ~we_reg;
        a_gnt = (owner_reg == PORT_A);
        b_gnt = (owner_reg == PORT_B);
        if (we_reg)        state_next = ST_IDLE;
        else if (HAS_WAIT) state_next = ST_WAIT;
        else               state_next = ST_DONE;
      end
      ST_WAIT: begin
        ram_e = 1'b1;
        if (cnt_reg == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        ram_e      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture read data in DONE and raise the owner's valid pulse on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid_reg <= 1'b0;
      b_rvalid_reg <= 1'b0;
      a_rdata_reg  <= '0;
      b_rdata_reg  <= '0;
    end else begin
      a_rvalid_reg <= (state_reg == ST_DONE) && (owner_reg == PORT_A);
      b_rvalid_reg <= (state_reg == ST_DONE) && (owner_reg == PORT_B);
      if (state_reg == ST_DONE && owner_reg == PORT_A) a_rdata_reg <= ram_dout;
      if (state_reg == ST_DONE && owner_reg == PORT_B) b_rdata_reg <= ram_dout;
    end
  end

  assign a_rvalid = a_rvalid_reg;
  assign b_rvalid = b_rvalid_reg;
  assign a_rdata  = a_rdata_reg;
  assign b_rdata  = b_rdata_reg;
  assign ram_addr = addr_reg;
  assign ram_din  = wdata_reg;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Bench for ram16k_arbiter: RD_LAT=1 instance checked every cycle against a
// transaction-timeline model, plus an RD_LAT=3 instance for the long-latency read.
module tb_ram16k_arbiter;
  localparam int AW = 14;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #3 clk = ~clk;

  // RD_LAT=1 instance
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_e, ram_w, ram_r;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] dout1 = '0;

  ram16k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_e(ram_e), .ram_w(ram_w), .ram_r(ram_r),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(dout1)
  );

  // RD_LAT=3 instance
  logic          x_req = 1'b0, x_we = 1'b0, y_req = 1'b0, y_we = 1'b0;
  logic [AW-1:0] x_addr = '0, y_addr = '0;
  logic [DW-1:0] x_wdata = '0, y_wdata = '0;
  logic          x_gnt, x_rvalid, y_gnt, y_rvalid;
  logic [DW-1:0] x_rdata, y_rdata;
  logic          ram3_e, ram3_w, ram3_r;
  logic [AW-1:0] ram3_addr;
  logic [DW-1:0] ram3_din;
  logic [DW-1:0] p0 = '0, p1 = '0, dout3 = '0;

  ram16k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .a_req(x_req), .a_we(x_we), .a_addr(x_addr), .a_wdata(x_wdata),
    .a_gnt(x_gnt), .a_rvalid(x_rvalid), .a_rdata(x_rdata),
    .b_req(y_req), .b_we(y_we), .b_addr(y_addr), .b_wdata(y_wdata),
    .b_gnt(y_gnt), .b_rvalid(y_rvalid), .b_rdata(y_rdata),
    .ram_e(ram3_e), .ram_w(ram3_w), .ram_r(ram3_r),
    .ram_addr(ram3_addr), .ram_din(ram3_din), .ram_dout(dout3)
  );

  // RAM16K models: latency 1 and latency 3 (registered read pipeline)
  logic [DW-1:0] mem1 [0:16383];
  logic [DW-1:0] mem3 [0:16383];
  always @(posedge clk) begin
    if (ram_e && ram_w) mem1[ram_addr] <= ram_din;
    if (ram_e && ram_r) dout1 <= mem1[ram_addr];
  end
  always @(posedge clk) begin
    if (ram3_e && ram3_w) mem3[ram3_addr] <= ram3_din;
    p0    <= (ram3_e && ram3_r) ? mem3[ram3_addr] : p0;
    p1    <= p0;
    dout3 <= p1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- transaction-timeline model (RD_LAT=1) ----------------
  localparam int MLAT = 1;
  int            cyc = 0;
  int            idle_from = 0;
  bit            mprio = 1'b0;
  int            act_start = -100, act_len = 0;
  bit            act_we = 1'b0, act_port = 1'b0;
  logic [AW-1:0] act_addr = '0;
  logic [DW-1:0] act_wdata = '0;
  int            rv_cycle = -100;
  bit            rv_port = 1'b0;
  logic [DW-1:0] rv_data = '0;
  logic [DW-1:0] exp_rdata_a = '0, exp_rdata_b = '0;
  bit   [DW-1:0] mmem [int];

  initial forever begin : model
    bit w;
    @(posedge clk);
    if (rst) begin
      idle_from   = cyc + 1;
      act_start   = -100;
      rv_cycle    = -100;
      mprio       = 1'b0;
      exp_rdata_a = '0;
      exp_rdata_b = '0;
    end else if (cyc >= idle_from && (a_req || b_req)) begin
      w         = (a_req && b_req) ? mprio : b_req;
      mprio     = ~w;
      act_start = cyc + 1;
      act_port  = w;
      act_we    = w ? b_we : a_we;
      act_addr  = w ? b_addr : a_addr;
      act_wdata = w ? b_wdata : a_wdata;
      if (act_we) begin
        mmem[int'(act_addr)] = act_wdata;
        act_len   = 1;
        idle_from = cyc + 2;
      end else begin
        act_len   = 1 + MLAT;
        rv_cycle  = cyc + MLAT + 2;
        rv_port   = w;
        rv_data   = mmem.exists(int'(act_addr)) ? mmem[int'(act_addr)] : '0;
        idle_from = cyc + MLAT + 2;
      end
    end
    cyc = cyc + 1;
    if (cyc == rv_cycle) begin
      if (rv_port) exp_rdata_b = rv_data;
      else         exp_rdata_a = rv_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  int cnt_w = 0, cnt_r = 0;
  int glog[$];

  initial forever begin : compare
    int  k;
    bit  e_on, e_acc;
    @(negedge clk);
    k     = cyc;
    e_on  = !rst && k >= act_start && k < act_start + act_len;
    e_acc = !rst && k == act_start;
    chk("cyc a_gnt", 32'(a_gnt), 32'(e_acc && act_port == 1'b0));
    chk("cyc b_gnt", 32'(b_gnt), 32'(e_acc && act_port == 1'b1));
    chk("cyc ram_e", 32'(ram_e), 32'(e_on));
    chk("cyc ram_w", 32'(ram_w), 32'(e_acc && act_we));
    chk("cyc ram_r", 32'(ram_r), 32'(e_acc && !act_we));
    if (e_on)          chk("cyc ram_addr", 32'(ram_addr), 32'(act_addr));
    if (e_acc && act_we) chk("cyc ram_din", 32'(ram_din), 32'(act_wdata));
    chk("cyc a_rvalid", 32'(a_rvalid), 32'(!rst && k == rv_cycle && rv_port == 1'b0));
    chk("cyc b_rvalid", 32'(b_rvalid), 32'(!rst && k == rv_cycle && rv_port == 1'b1));
    chk("cyc a_rdata", 32'(a_rdata), 32'(rst ? 16'h0 : exp_rdata_a));
    chk("cyc b_rdata", 32'(b_rdata), 32'(rst ? 16'h0 : exp_rdata_b));
    if (ram_w) cnt_w++;
    if (ram_r) cnt_r++;
    if (a_gnt) glog.push_back(0);
    if (b_gnt) glog.push_back(1);
  end

  // One single-word command; holds req until gnt, then waits for read data.
  task automatic cmd(input bit port, input bit we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input bit chk_lat, input logic [DW-1:0] want_rd);
    int n;
    bit got;
    @(negedge clk);
    if (port) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
    else      begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      got = port ? b_gnt : a_gnt;
    end
    if (port) b_req = 1'b0; else a_req = 1'b0;
    chk("gnt_seen", 32'(got), 32'd1);
    if (chk_lat) chk("gnt_latency", 32'(n), 32'd1);
    if (!we) begin
      got = 1'b0;
      while (!got && n < 40) begin
        @(negedge clk); n++;
        got = port ? b_rvalid : a_rvalid;
      end
      chk("rvalid_seen", 32'(got), 32'd1);
      if (chk_lat) chk("rvalid_latency", 32'(n), 32'd3);
      chk("rdata", 32'(port ? b_rdata : a_rdata), 32'(want_rd));
    end
    $display("[TB] cmd port=%s we=%0d addr=%0d wdata=%h cycles=%0d", port ? "B" : "A", we, addr, wd, n);
  endtask

  initial begin : watchdog
    #60000;
    $display("FAIL watchdog: got no finish required finish before t=60000");
    $fatal(1);
  end

  initial begin : stim
    int addrs[4];
    int n, w0, r0, rcnt;
    bit ord[$];
    bit got;
    addrs = '{0, 1000, 2000, 3000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst a_gnt",    32'(a_gnt), 32'd0);
    chk("rst b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst ram_e",    32'(ram_e), 32'd0);
    chk("rst ram_addr", 32'(ram_addr), 32'd0);
    chk("rst x_rdata",  32'(x_rdata), 32'd0);
    rst = 1'b0;

    // Simultaneous requests straight after reset: A wins, then B reads A's data
    glog.delete();
    fork
      cmd(1'b0, 1'b1, 14'd5, 16'hAAAA, 1'b1, 16'h0);
      cmd(1'b1, 1'b0, 14'd5, 16'h0,    1'b0, 16'hAAAA);
    join
    chk("t3 grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("t3 first",  32'(glog[0]), 32'd0);
      chk("t3 second", 32'(glog[1]), 32'd1);
    end

    // A writes 0..3
    w0 = cnt_w; r0 = cnt_r;
    for (int i = 0; i < 4; i++) cmd(1'b0, 1'b1, 14'(addrs[i]), 16'(i), 1'b1, 16'h0);
    @(negedge clk);
    chk("t1 ram_w cycles", 32'(cnt_w - w0), 32'd4);
    chk("t1 ram_r cycles", 32'(cnt_r - r0), 32'd0);

    // B reads them back
    for (int i = 0; i < 4; i++) cmd(1'b1, 1'b0, 14'(addrs[i]), 16'h0, 1'b1, 16'(i));

    // Both hold req: grants must alternate A,B,A,B,A,B
    @(negedge clk);
    a_we = 1'b1; a_addr = 14'd100; a_wdata = 16'h1111;
    b_we = 1'b1; b_addr = 14'd200; b_wdata = 16'h2222;
    a_req = 1'b1; b_req = 1'b1;
    n = 0;
    while (ord.size() < 6 && n < 40) begin
      @(negedge clk); n++;
      if (a_gnt) ord.push_back(1'b0);
      if (b_gnt) ord.push_back(1'b1);
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("t4 grant count", 32'(ord.size()), 32'd6);
    for (int i = 0; i < ord.size() && i < 6; i++) begin
      chk("t4 order", 32'(ord[i]), 32'(i % 2));
      $display("[TB] t4 grant %0d -> %s", i, ord[i] ? "B" : "A");
    end
    cmd(1'b0, 1'b0, 14'd200, 16'h0, 1'b1, 16'h2222);

    // Reset during DONE of a read
    @(negedge clk);
    b_we = 1'b0; b_addr = 14'd1000; b_req = 1'b1;
    @(negedge clk);
    chk("t5 gnt", 32'(b_gnt), 32'd1);
    b_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5 ram_e",    32'(ram_e), 32'd0);
    chk("t5 ram_addr", 32'(ram_addr), 32'd0);
    chk("t5 b_rvalid", 32'(b_rvalid), 32'd0);
    chk("t5 b_rdata",  32'(b_rdata), 32'd0);
    $display("[TB] t5 reset asserted mid-read");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t5 no rvalid", 32'(b_rvalid), 32'd0);
    end
    cmd(1'b1, 1'b0, 14'd2000, 16'h0, 1'b1, 16'd2);

    // RD_LAT=3 instance: write then read the top address
    @(negedge clk);
    x_we = 1'b1; x_addr = 14'd16383; x_wdata = 16'h5A5A; x_req = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin @(negedge clk); n++; got = x_gnt; end
    x_req = 1'b0;
    chk("t6 write gnt latency", 32'(n), 32'd1);
    @(negedge clk);
    x_we = 1'b0; x_req = 1'b1;
    n = 0; rcnt = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (ram3_r) rcnt++;
      if (x_gnt) x_req = 1'b0;
      chk("t6 y_gnt", 32'(y_gnt), 32'd0);
      got = x_rvalid;
    end
    x_req = 1'b0;
    chk("t6 rvalid latency", 32'(n), 32'd5);
    chk("t6 ram_r cycles",   32'(rcnt), 32'd1);
    chk("t6 rdata",          32'(x_rdata), 32'h5A5A);
    $display("[TB] t6 read addr=16383 latency=%0d rdata=%h", n, x_rdata);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
